// File: rtl/chiptune_pkg.sv
// rtl/chiptune_pkg.sv - shared types and helpers for the chiptune serial blocks
package chiptune_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  // Bit period in clocks, rounded to nearest.
  function automatic int baud_div(input int clkrate, input int baudrate);
    return (clkrate + baudrate / 2) / baudrate;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with extra-bit pointers and occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointer MSBs differ only when the write side has lapped the read side.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - buffered 8N1 UART transmitter, LSB first
module serial_tx
  import chiptune_pkg::*;
#(
  parameter int CLKRATE  = 12_000_000,
  parameter int BAUDRATE = 9600,
  parameter int DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  localparam int DIV = baud_div(CLKRATE, BAUDRATE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(DEPTH);
  localparam logic [CW-1:0] LOAD = CW'(DIV - 1);

  tx_state_t     state, state_next;
  logic [CW-1:0] baud_cnt, baud_next;
  logic [7:0]    shift, shift_next;
  logic [2:0]    bit_idx, bit_next;
  logic          tx_next;
  logic          pop;
  logic          full;
  logic          empty;
  logic [7:0]    fifo_data;
  logic [AW:0]   count;
  logic          tc;

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (valid && ready),
    .push_data (data),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign ready = !full;
  assign busy  = (state != IDLE) || (count != '0);
  assign tc    = (baud_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      shift    <= '0;
      bit_idx  <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      shift    <= shift_next;
      bit_idx  <= bit_next;
      tx       <= tx_next;
    end
  end

  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    shift_next = shift;
    bit_next   = bit_idx;
    tx_next    = tx;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (!empty) begin
          pop        = 1'b1;
          shift_next = fifo_data;
          bit_next   = '0;
          baud_next  = LOAD;
          tx_next    = 1'b0;
          state_next = START;
        end
      end
      START: begin
        if (tc) begin
          baud_next  = LOAD;
          tx_next    = shift[0];
          state_next = DATA;
        end else begin
          baud_next = baud_cnt - CW'(1);
        end
      end
      DATA: begin
        if (tc) begin
          baud_next = LOAD;
          if (bit_idx == 3'd7) begin
            tx_next    = 1'b1;
            state_next = STOP;
          end else begin
            bit_next   = bit_idx + 3'd1;
            shift_next = {1'b0, shift[7:1]};
            tx_next    = shift[1];
          end
        end else begin
          baud_next = baud_cnt - CW'(1);
        end
      end
      STOP: begin
        if (tc) begin
          // Pop straight into the next start bit so queued frames abut.
          if (!empty) begin
            pop        = 1'b1;
            shift_next = fifo_data;
            bit_next   = '0;
            baud_next  = LOAD;
            tx_next    = 1'b0;
            state_next = START;
          end else begin
            tx_next    = 1'b1;
            state_next = IDLE;
          end
        end else begin
          baud_next = baud_cnt - CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_tx.sv
// tb/tb_serial_tx.sv - directed self-checking bench for serial_tx
module tb_serial_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, valid, ready, tx, busy;
  logic [7:0] data;
  logic       d_rst, d_valid, d_ready, d_tx, d_busy;
  logic [7:0] d_data;

  serial_tx #(.CLKRATE(16), .BAUDRATE(1), .DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .data(data), .valid(valid),
    .ready(ready), .tx(tx), .busy(busy)
  );

  serial_tx u_def (
    .clk(clk), .rst(d_rst), .data(d_data), .valid(d_valid),
    .ready(d_ready), .tx(d_tx), .busy(d_busy)
  );

  int         total = 0;
  int         bad   = 0;
  logic [7:0] vals    [6];
  logic [7:0] acc_val [6];
  time        acc_t   [6];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Holds valid across bytes; optionally scrambles data while stalled.
  task automatic producer(input int n, input bit toggle);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      data  = vals[i];
      valid = 1'b1;
      for (int g = 0; g < 400 && !ready; g++) begin
        @(negedge clk);
        if (toggle) data = data ^ 8'h5A;
      end
      if (!ready) check("accept_timeout", {31'd0, ready}, 32'd1);
      @(posedge clk);
      acc_val[i] = data;
      acc_t[i]   = $time;
    end
    @(negedge clk);
    valid = 1'b0;
  endtask

  // Entered on the first negedge sample of a start bit.
  task automatic rx_body(output logic [7:0] b);
    repeat (8) @(negedge clk);
    check("start_bit", {31'd0, tx}, 32'd0);
    for (int j = 0; j < 8; j++) begin
      repeat (16) @(negedge clk);
      b[j] = tx;
    end
    repeat (16) @(negedge clk);
    check("stop_bit", {31'd0, tx}, 32'd1);
  endtask

  task automatic rx_frame(output logic [7:0] b, output time t);
    int g = 0;
    while (tx !== 1'b0 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    check("frame_seen", {31'd0, tx}, 32'd0);
    t = $time;
    rx_body(b);
  endtask

  task automatic receiver(input int n);
    logic [7:0] b;
    time        t, prev;
    prev = 0;
    for (int k = 0; k < n; k++) begin
      rx_frame(b, t);
      check("frame_data", {24'd0, b}, {24'd0, acc_val[k]});
      if (k > 0) check("frame_gap", 32'(t - prev), 32'd1600);
      prev = t;
    end
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 5000) begin
      @(negedge clk);
      g++;
    end
    check("idle", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    logic       seen;
    int         n, m;

    rst = 1'b1; valid = 1'b0; data = 8'h00;
    d_rst = 1'b1; d_valid = 1'b0; d_data = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_tx",    {31'd0, tx},    32'd1);
    check("reset_ready", {31'd0, ready}, 32'd1);
    check("reset_busy",  {31'd0, busy},  32'd0);
    rst = 1'b0; d_rst = 1'b0;
    @(negedge clk);

    // single byte 0x55
    data = 8'h55; valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    check("sb_tx_after_accept", {31'd0, tx}, 32'd1);
    check("sb_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("sb_tx_fall", {31'd0, tx}, 32'd0);
    rx_body(b);
    check("sb_data", {24'd0, b}, 32'h55);
    repeat (7) @(negedge clk);
    check("sb_busy_last_stop", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("sb_busy_end", {31'd0, busy}, 32'd0);
    check("sb_tx_idle", {31'd0, tx}, 32'd1);
    wait_idle();

    // fill and stall, constant data
    for (int i = 0; i < 6; i++) vals[i] = 8'(i + 1);
    fork
      producer(6, 1'b0);
      receiver(6);
    join
    check("fill_burst", 32'(acc_t[4] - acc_t[0]), 32'd40);
    check("fill_stall", 32'(acc_t[5] - acc_t[0]), 32'd1620);
    wait_idle();

    // held valid while full with data toggling
    for (int i = 0; i < 6; i++) vals[i] = 8'(8'h10 + i);
    fork
      producer(6, 1'b1);
      receiver(6);
    join
    check("held_value", {24'd0, acc_val[5]}, 32'h4F);
    check("held_stall", 32'(acc_t[5] - acc_t[0]), 32'd1620);
    wait_idle();

    // reset during data bit 3 of 0xA3 with two bytes queued
    vals[0] = 8'hA3; vals[1] = 8'h01; vals[2] = 8'h02;
    producer(3, 1'b0);
    repeat (70) @(negedge clk);
    check("rst_bit3", {31'd0, tx}, 32'd0);
    check("rst_ready_full_pre", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_tx",    {31'd0, tx},    32'd1);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_busy",  {31'd0, busy},  32'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) seen = 1'b1;
    end
    check("rst_no_stale", {31'd0, seen}, 32'd0);

    // back-to-back: second byte accepted on the edge opening the last stop clock
    vals[0] = 8'h3C;
    producer(1, 1'b0);
    @(negedge clk);
    check("b2b_first_start", {31'd0, tx}, 32'd0);
    repeat (158) @(negedge clk);
    data = 8'hC5; valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    check("b2b_stop", {31'd0, tx}, 32'd1);
    @(negedge clk);
    check("b2b_start", {31'd0, tx}, 32'd0);
    rx_body(b);
    check("b2b_data", {24'd0, b}, 32'hC5);
    wait_idle();

    // default rate, byte 0x00
    @(negedge clk);
    d_data = 8'h00; d_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    d_valid = 1'b0;
    n = 0;
    while (d_tx !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("def_fall", {31'd0, d_tx}, 32'd0);
    n = 0;
    while (d_tx === 1'b0 && n < 20000) begin
      n++;
      @(negedge clk);
    end
    check("def_low", 32'(n), 32'd11250);
    m = 0;
    while (d_busy && m < 5000) begin
      if (d_tx !== 1'b1) seen = 1'b1;
      m++;
      @(negedge clk);
    end
    check("def_high", 32'(m), 32'd1250);
    check("def_tx_end", {31'd0, d_tx}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
